// File: rtl/read_cmd_executor.sv
// Read-command sink: decodes {eop, len, addr} commands, issues credit-limited Avalon-MM
// burst reads and streams the returned words out over AXI-stream with tlast framing.

module read_cmd_executor_chk #(
    parameter int FIFO_DEPTH = 64,
    parameter int CW         = 7
) (
    input logic          clk,
    input logic          reset,
    input logic          push,
    input logic          pop,
    input logic [CW-1:0] count
);
    // The return FIFO must never be written while full without a matching pop.
    overflow_a: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (count == CW'(FIFO_DEPTH))));
endmodule

module read_cmd_executor #(
    parameter int DATA_W     = 64,
    parameter int MAX_BURST  = 16,
    parameter int BURST_W    = 5,
    parameter int FIFO_DEPTH = 64
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    input  logic               cmd_tvalid,
    output logic               cmd_tready,
    input  logic [96:0]        cmd_tdata,
    output logic [63:0]        avm_address,
    output logic               avm_read,
    output logic [BURST_W-1:0] avm_burstcount,
    input  logic               avm_waitrequest,
    input  logic [DATA_W-1:0]  avm_readdata,
    input  logic               avm_readdatavalid,
    output logic               out_tvalid,
    input  logic               out_tready,
    output logic [DATA_W-1:0]  out_tdata,
    output logic               out_tlast,
    output logic               busy,
    output logic [31:0]        cmd_done_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = CW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_r, state_n;
    logic [63:0]         addr_r, addr_n;
    logic [32:0]         remaining_r, remaining_n;
    logic [32:0]         beats_r, beats_n;
    logic [32:0]         recv_r, recv_n;
    logic                last_flag_r, last_flag_n;
    logic [CW-1:0]       outstanding_r, outstanding_n;
    logic [CW-1:0]       fifo_count_r, fifo_count_n;
    logic [AW-1:0]       wr_ptr_r, rd_ptr_r;
    logic [DATA_W:0]     mem_r [FIFO_DEPTH];
    logic                avm_read_r, avm_read_n;
    logic [63:0]         avm_address_r, avm_address_n;
    logic [BURST_W-1:0]  avm_burstcount_r, avm_burstcount_n;
    logic                cmd_tready_r;
    logic                busy_r;
    logic [31:0]         done_count_r;

    logic                hs_s, push_s, pop_s, accept_s, done_inc_s, last_bit_s, out_tvalid_s;
    logic [31:0]         dec_len_s;
    logic [32:0]         dec_beats_s;
    logic [BURST_W-1:0]  burst_n_s;
    logic [RW-1:0]       reserved_n_s;
    logic [DATA_W:0]     head_s;
    logic                unused_s;

    assign hs_s         = cmd_tvalid && cmd_tready_r;
    assign dec_len_s    = cmd_tdata[95:64];
    assign dec_beats_s  = ({1'b0, dec_len_s} + 33'd7) >> 3'd3;
    assign unused_s     = ^cmd_tdata[2:0];
    // Responses with nothing outstanding are leftovers from before a reset and are dropped.
    assign push_s       = avm_readdatavalid && (outstanding_r != {CW{1'b0}});
    assign out_tvalid_s = (fifo_count_r != {CW{1'b0}});
    assign pop_s        = out_tvalid_s && out_tready;
    assign last_bit_s   = last_flag_r && ((recv_r + 33'd1) == beats_r);
    assign head_s       = mem_r[rd_ptr_r];

    // Command decode, FSM next state and credit bookkeeping.
    always_comb begin
        state_n     = state_r;
        addr_n      = addr_r;
        remaining_n = remaining_r;
        beats_n     = beats_r;
        last_flag_n = last_flag_r;
        recv_n      = push_s ? (recv_r + 33'd1) : recv_r;
        accept_s    = 1'b0;
        done_inc_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (hs_s) begin
                    if (dec_len_s == 32'd0) begin
                        done_inc_s = 1'b1;
                    end else begin
                        state_n     = ISSUE;
                        addr_n      = {cmd_tdata[63:3], 3'b000};
                        remaining_n = dec_beats_s;
                        beats_n     = dec_beats_s;
                        last_flag_n = cmd_tdata[96];
                        recv_n      = 33'd0;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            ISSUE: begin
                if (avm_read_r && !avm_waitrequest) begin
                    accept_s    = 1'b1;
                    addr_n      = addr_r + (64'(avm_burstcount_r) << 3'd3);
                    remaining_n = remaining_r - 33'(avm_burstcount_r);
                    if (remaining_n == 33'd0) begin
                        state_n = DRAIN;
                    end else begin
                        state_n = ISSUE;
                    end
                end else begin
                    state_n = ISSUE;
                end
            end
            DRAIN: begin
                if ((outstanding_r == {CW{1'b0}}) && (recv_r == beats_r)) begin
                    state_n    = IDLE;
                    done_inc_s = 1'b1;
                end else begin
                    state_n = DRAIN;
                end
            end
            default: state_n = IDLE;
        endcase
        outstanding_n = outstanding_r - CW'(push_s)
                      + (accept_s ? CW'(avm_burstcount_r) : {CW{1'b0}});
        fifo_count_n  = fifo_count_r + CW'(push_s) - CW'(pop_s);
    end

    // Next Avalon request: held through waitrequest, otherwise issued when the credits cover it.
    always_comb begin
        burst_n_s    = (remaining_n >= 33'(MAX_BURST)) ? BURST_W'(MAX_BURST) : BURST_W'(remaining_n);
        reserved_n_s = RW'(fifo_count_n) + RW'(outstanding_n) + RW'(burst_n_s);
        if (avm_read_r && avm_waitrequest) begin
            avm_read_n       = 1'b1;
            avm_address_n    = avm_address_r;
            avm_burstcount_n = avm_burstcount_r;
        end else begin
            avm_read_n       = (state_n == ISSUE) && (remaining_n != 33'd0)
                             && (reserved_n_s <= RW'(FIFO_DEPTH));
            avm_address_n    = avm_read_n ? addr_n : avm_address_r;
            avm_burstcount_n = avm_read_n ? burst_n_s : avm_burstcount_r;
        end
    end

    // Control, request and counter registers.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_r          <= IDLE;
            addr_r           <= 64'd0;
            remaining_r      <= 33'd0;
            beats_r          <= 33'd0;
            recv_r           <= 33'd0;
            last_flag_r      <= 1'b0;
            outstanding_r    <= {CW{1'b0}};
            fifo_count_r     <= {CW{1'b0}};
            wr_ptr_r         <= {AW{1'b0}};
            rd_ptr_r         <= {AW{1'b0}};
            avm_read_r       <= 1'b0;
            avm_address_r    <= 64'd0;
            avm_burstcount_r <= {BURST_W{1'b0}};
            cmd_tready_r     <= 1'b0;
            busy_r           <= 1'b0;
            done_count_r     <= 32'd0;
        end else begin
            state_r          <= state_n;
            addr_r           <= addr_n;
            remaining_r      <= remaining_n;
            beats_r          <= beats_n;
            recv_r           <= recv_n;
            last_flag_r      <= last_flag_n;
            outstanding_r    <= outstanding_n;
            fifo_count_r     <= fifo_count_n;
            wr_ptr_r         <= wr_ptr_r + AW'(push_s);
            rd_ptr_r         <= rd_ptr_r + AW'(pop_s);
            avm_read_r       <= avm_read_n;
            avm_address_r    <= avm_address_n;
            avm_burstcount_r <= avm_burstcount_n;
            cmd_tready_r     <= (state_n == IDLE);
            busy_r           <= (state_n != IDLE);
            done_count_r     <= done_count_r + {31'd0, done_inc_s};
        end
    end

    // Return-data storage; emptiness is tracked by the pointers and count only.
    always_ff @(posedge clk_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {last_bit_s, avm_readdata};
        end
    end

    read_cmd_executor_chk #(.FIFO_DEPTH(FIFO_DEPTH), .CW(CW)) u_chk (
        .clk   (clk_clk),
        .reset (reset_reset),
        .push  (push_s),
        .pop   (pop_s),
        .count (fifo_count_r)
    );

    assign cmd_tready     = cmd_tready_r;
    assign avm_read       = avm_read_r;
    assign avm_address    = avm_address_r;
    assign avm_burstcount = avm_burstcount_r;
    assign out_tvalid     = out_tvalid_s;
    assign out_tdata      = head_s[DATA_W-1:0];
    assign out_tlast      = out_tvalid_s && head_s[DATA_W];
    assign busy           = busy_r;
    assign cmd_done_count = done_count_r;
endmodule

// File: tb/tb_read_cmd_executor.sv
// Randomised scoreboard bench for read_cmd_executor with an Avalon memory model
// and a command-level reference of expected bursts and output beats.

module tb_read_cmd_executor;
    logic        clk_clk;
    logic        reset_reset;
    logic        cmd_tvalid;
    logic        cmd_tready;
    logic [96:0] cmd_tdata;
    logic [63:0] avm_address;
    logic        avm_read;
    logic [4:0]  avm_burstcount;
    logic        avm_waitrequest;
    logic [63:0] avm_readdata;
    logic        avm_readdatavalid;
    logic        out_tvalid;
    logic        out_tready;
    logic [63:0] out_tdata;
    logic        out_tlast;
    logic        busy;
    logic [31:0] cmd_done_count;

    read_cmd_executor dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready), .cmd_tdata(cmd_tdata),
        .avm_address(avm_address), .avm_read(avm_read), .avm_burstcount(avm_burstcount),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
        .out_tlast(out_tlast), .busy(busy), .cmd_done_count(cmd_done_count)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [64:0] exp_q[$];        // {tlast, data} per expected output beat
    logic [68:0] exp_burst_q[$];  // {address, burstcount} per expected burst
    logic [63:0] resp_q[$];       // addresses still to be returned by memory
    int          acc_total = 0;
    int          pop_total = 0;
    int          exp_done = 0;
    int          rdy_mode = 0;    // 0 hold low, 1 always ready, 2 random
    int          wr_mode = 0;     // 0 never stall, 1 random stalls
    int          resp_mode = 0;   // 0 withhold data, 1 every cycle, 2 random gaps
    int          stall_budget = 0;
    int          stall_run = 0;
    int          last_stall_run = 0;

    initial begin
        clk_clk = 1'b0;
        forever #5 clk_clk = ~clk_clk;
    end

    function automatic logic [63:0] memfn(input logic [63:0] a);
        return {a[63:32] ^ ~a[31:0], a[31:0] ^ 32'h5A5A_1234};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk_clk);
        #1;
    endtask

    // Memory / sink driver: ready, waitrequest and read responses change just after the edge.
    initial begin
        out_tready = 1'b0;
        avm_waitrequest = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata = 64'd0;
        forever begin
            @(posedge clk_clk);
            #1;
            out_tready = (rdy_mode == 1) || ((rdy_mode == 2) && ($urandom_range(0, 99) < 70));
            if ((stall_budget > 0) && avm_read) begin
                avm_waitrequest = 1'b1;
                stall_budget--;
            end else begin
                avm_waitrequest = (wr_mode == 1) && ($urandom_range(0, 99) < 30);
            end
            if ((resp_q.size() > 0) &&
                ((resp_mode == 1) || ((resp_mode == 2) && ($urandom_range(0, 99) < 60)))) begin
                avm_readdatavalid = 1'b1;
                avm_readdata = memfn(resp_q.pop_front());
            end else begin
                avm_readdatavalid = 1'b0;
                avm_readdata = {$urandom, $urandom};
            end
        end
    end

    // Output monitor: every transferred beat is checked against the scoreboard head.
    initial begin
        logic [64:0] e;
        forever begin
            @(negedge clk_clk);
            if (!reset_reset && out_tvalid && out_tready) begin
                pop_total++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_beat: actual data=%h last=%b required=no beat",
                             out_tdata, out_tlast);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_tdata", out_tdata, e[63:0]);
                    chk("out_tlast", 64'(out_tlast), 64'(e[64]));
                end
            end
        end
    end

    // Avalon monitor: request stability, credit limit and burst sequence.
    initial begin
        logic        prev_stall;
        logic [63:0] prev_addr;
        logic [4:0]  prev_burst;
        logic [68:0] b;
        prev_stall = 1'b0;
        prev_addr = 64'd0;
        prev_burst = 5'd0;
        forever begin
            @(negedge clk_clk);
            if (reset_reset) begin
                prev_stall = 1'b0;
                stall_run = 0;
            end else begin
                if (prev_stall) begin
                    chk("stall_read", 64'(avm_read), 64'd1);
                    chk("stall_addr", avm_address, prev_addr);
                    chk("stall_burst", 64'(avm_burstcount), 64'(prev_burst));
                end
                if (avm_read && !avm_waitrequest) begin
                    last_stall_run = stall_run;
                    stall_run = 0;
                    chk("credit", 64'((acc_total - pop_total + int'(avm_burstcount)) <= 64), 64'd1);
                    if (exp_burst_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_burst: actual addr=%h count=%0d required=none",
                                 avm_address, avm_burstcount);
                    end else begin
                        b = exp_burst_q.pop_front();
                        chk("burst_addr", avm_address, b[68:5]);
                        chk("burst_count", 64'(avm_burstcount), 64'(b[4:0]));
                    end
                    for (int i = 0; i < int'(avm_burstcount); i++) begin
                        resp_q.push_back(avm_address + 64'(8 * i));
                    end
                    acc_total += int'(avm_burstcount);
                end else if (avm_read) begin
                    stall_run++;
                end
                prev_stall = avm_read && avm_waitrequest;
                prev_addr = avm_address;
                prev_burst = avm_burstcount;
            end
        end
    end

    // Reference model: a command expands into aligned beats and bursts of at most 16.
    task automatic model_cmd(input logic [63:0] addr, input logic [31:0] len, input logic eop);
        logic [63:0] a;
        longint      beats;
        longint      rem;
        longint      bl;
        a = {addr[63:3], 3'b000};
        beats = (longint'(len) + 64'sd7) / 64'sd8;
        for (longint i = 0; i < beats; i++) begin
            exp_q.push_back({eop && (i == beats - 1), memfn(a + 64'(8 * i))});
        end
        rem = beats;
        while (rem > 0) begin
            bl = (rem > 16) ? 16 : rem;
            exp_burst_q.push_back({a, 5'(bl)});
            a = a + 64'(8 * bl);
            rem = rem - bl;
        end
        exp_done++;
    endtask

    // Caller is just after a rising edge; returns just after the handshake edge.
    task automatic send_cmd(input logic [63:0] addr, input logic [31:0] len,
                            input logic eop, input logic hold);
        int budget;
        budget = 0;
        cmd_tdata = {eop, len, addr};
        cmd_tvalid = 1'b1;
        forever begin
            @(negedge clk_clk);
            if (cmd_tready) break;
            budget++;
            if (budget > 5000) break;
        end
        if (budget > 5000) begin
            n_cmp++;
            n_err++;
            $display("FAIL cmd_accept_timeout: actual cmd_tready=0 required=1");
        end else begin
            model_cmd(addr, len, eop);
        end
        sync();
        cmd_tvalid = hold;
    endtask

    task automatic wait_idle();
        int  budget;
        logic idle;
        budget = 0;
        idle = 1'b0;
        while (!idle && budget < 20000) begin
            @(negedge clk_clk);
            budget++;
            idle = (exp_q.size() == 0) && (exp_burst_q.size() == 0) &&
                   (resp_q.size() == 0) && !busy;
        end
        if (!idle) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: actual busy=%b pending=%0d required=idle",
                     busy, exp_q.size());
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cmd_tready"}, 64'(cmd_tready), 64'd0);
        chk({tag, "_avm_read"}, 64'(avm_read), 64'd0);
        chk({tag, "_avm_address"}, avm_address, 64'd0);
        chk({tag, "_avm_burstcount"}, 64'(avm_burstcount), 64'd0);
        chk({tag, "_out_tvalid"}, 64'(out_tvalid), 64'd0);
        chk({tag, "_out_tlast"}, 64'(out_tlast), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done_count"}, 64'(cmd_done_count), 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: actual=simulation still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          base;
        int          budget;
        logic [63:0] ra;
        logic [31:0] rl;
        logic        hold;
        reset_reset = 1'b1;
        cmd_tvalid = 1'b0;
        cmd_tdata = 97'd0;
        repeat (3) @(posedge clk_clk);
        @(negedge clk_clk);
        check_reset_vals("por");
        sync();
        reset_reset = 1'b0;
        @(posedge clk_clk);
        @(negedge clk_clk);
        chk("ready_after_reset", 64'(cmd_tready), 64'd1);

        // Single 4-beat burst with tlast on the final beat.
        rdy_mode = 1;
        resp_mode = 1;
        sync();
        send_cmd(64'h1000, 32'd32, 1'b1, 1'b0);
        @(negedge clk_clk);
        chk("busy_active", 64'(busy), 64'd1);
        wait_idle();
        chk("done_count_t1", 64'(cmd_done_count), 64'(exp_done));

        // 25 beats while the sink is stalled: bursts of 16 and 9.
        rdy_mode = 0;
        base = acc_total;
        sync();
        send_cmd(64'h4000_0000, 32'd200, 1'b1, 1'b0);
        repeat (60) @(negedge clk_clk);
        chk("stalled_accepted", 64'(acc_total - base), 64'd25);
        chk("stalled_valid", 64'(out_tvalid), 64'd1);
        rdy_mode = 1;
        wait_idle();

        // Credit limit: a stalled sink caps the reads at the FIFO depth.
        rdy_mode = 0;
        base = acc_total;
        sync();
        send_cmd(64'h8000, 32'd1000, 1'b1, 1'b0);
        repeat (120) @(negedge clk_clk);
        chk("credit_cap", 64'(acc_total - base), 64'd64);
        chk("credit_no_read", 64'(avm_read), 64'd0);
        rdy_mode = 1;
        wait_idle();

        // Zero-length command, then one beat without eop.
        sync();
        base = acc_total;
        send_cmd(64'h2000, 32'd0, 1'b1, 1'b0);
        @(negedge clk_clk);
        chk("zero_len_count", 64'(cmd_done_count), 64'(exp_done));
        chk("zero_len_no_read", 64'(acc_total - base), 64'd0);
        sync();
        send_cmd(64'h3000, 32'd8, 1'b0, 1'b0);
        wait_idle();
        chk("done_count_t3", 64'(cmd_done_count), 64'(exp_done));

        // Five cycles of waitrequest on the first burst.
        stall_budget = 5;
        sync();
        send_cmd(64'hABC0, 32'd64, 1'b1, 1'b0);
        wait_idle();
        chk("stall_cycles", 64'(last_stall_run), 64'd5);

        // Unaligned start that wraps past the top of the address space.
        sync();
        send_cmd(64'hFFFF_FFFF_FFFF_FFE5, 32'd40, 1'b1, 1'b0);
        wait_idle();

        // Three back-to-back commands with cmd_tvalid held high.
        sync();
        send_cmd(64'h5000, 32'd8, 1'b1, 1'b1);
        send_cmd(64'h6000, 32'd16, 1'b0, 1'b1);
        send_cmd(64'h7000, 32'd24, 1'b1, 1'b0);
        wait_idle();
        chk("done_count_b2b", 64'(cmd_done_count), 64'(exp_done));

        // Reset with 8 beats outstanding, then stale responses.
        resp_mode = 0;
        base = acc_total;
        sync();
        send_cmd(64'h9000, 32'd64, 1'b1, 1'b0);
        budget = 0;
        while ((acc_total - base) < 8 && budget < 200) begin
            @(negedge clk_clk);
            budget++;
        end
        chk("pre_reset_outstanding", 64'(acc_total - base), 64'd8);
        sync();
        reset_reset = 1'b1;
        repeat (2) @(posedge clk_clk);
        @(negedge clk_clk);
        check_reset_vals("mid");
        exp_q.delete();
        exp_burst_q.delete();
        acc_total = 0;
        pop_total = 0;
        exp_done = 0;
        sync();
        reset_reset = 1'b0;
        resp_mode = 1;
        repeat (14) @(negedge clk_clk);
        chk("post_reset_ready", 64'(cmd_tready), 64'd1);
        chk("post_reset_valid", 64'(out_tvalid), 64'd0);
        chk("post_reset_busy", 64'(busy), 64'd0);
        chk("post_reset_count", 64'(cmd_done_count), 64'd0);

        // Randomised commands with random stalls on every interface.
        wr_mode = 1;
        rdy_mode = 2;
        resp_mode = 2;
        sync();
        for (int i = 0; i < 30; i++) begin
            ra = {$urandom, $urandom};
            if ((i % 7) == 3) ra = 64'hFFFF_FFFF_FFFF_FF00 + 64'($urandom_range(0, 255));
            rl = 32'($urandom_range(0, 300));
            if ((i % 9) == 4) rl = 32'd0;
            hold = (i != 29) && ($urandom_range(0, 1) == 1);
            send_cmd(ra, rl, 1'($urandom_range(0, 1)), hold);
        end
        wait_idle();
        chk("done_count_random", 64'(cmd_done_count), 64'(exp_done));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
